kbest_symbol_reorder_demap: RTL and testbench



---
 rtl/kbest_symbol_reorder_demap.sv | 120 ++++++++++++
 tb/tb_kbest_symbol_reorder_demap.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbest_symbol_reorder_demap.sv
// K-best output stage: undoes the QR column permutation, Gray-demaps
// PAM4 symbols and hands out one double-buffered frame of bits.
module kbest_symbol_reorder_demap #(
  parameter int N_DIM = 8,
  parameter int SYM_W = 3,
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W*N_DIM-1:0]  colorder,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic signed [SYM_W-1:0] sym_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*N_DIM-1:0]      bits_out,
  output logic                    sym_err,
  output logic                    order_err
);

  localparam logic signed [SYM_W-1:0] LVL_M3 = SYM_W'(-3);
  localparam logic signed [SYM_W-1:0] LVL_M1 = SYM_W'(-1);
  localparam logic signed [SYM_W-1:0] LVL_P1 = SYM_W'(1);
  localparam logic signed [SYM_W-1:0] LVL_P3 = SYM_W'(3);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N_DIM - 1);

  logic [IDX_W-1:0]       cnt;
  logic [IDX_W*N_DIM-1:0] lat_order;
  logic [IDX_W*N_DIM-1:0] order_sel;
  logic [2*N_DIM-1:0]     fill_bits;
  logic [2*N_DIM-1:0]     nxt_bits;
  logic [N_DIM-1:0]       fill_wr;
  logic [N_DIM-1:0]       nxt_wr;
  logic                   fill_serr;
  logic                   fill_oerr;
  logic                   nxt_serr;
  logic                   nxt_oerr;
  logic                   fill_full;
  logic [IDX_W-1:0]       lay;
  logic [IDX_W-1:0]       slot;
  logic [1:0]             gray;
  logic                   bad;
  logic                   sym_xfer;
  logic                   out_free;
  logic                   last;

  assign sym_ready = !fill_full;
  assign sym_xfer  = sym_valid && sym_ready;
  assign out_free  = !out_valid || out_ready;
  assign last      = (cnt == CNT_LAST);

  always_comb begin
    gray = 2'b00;
    bad  = 1'b0;
    case (sym_in)
      LVL_M3:  gray = 2'b00;
      LVL_M1:  gray = 2'b01;
      LVL_P1:  gray = 2'b11;
      LVL_P3:  gray = 2'b10;
      default: bad  = 1'b1;
    endcase
  end

  // First symbol of a frame starts from a clean buffer and the live order
  always_comb begin
    order_sel = (cnt == '0) ? colorder : lat_order;
    lay       = CNT_LAST - cnt;
    slot      = order_sel[IDX_W*lay +: IDX_W];
    nxt_bits  = (cnt == '0) ? '0 : fill_bits;
    nxt_wr    = (cnt == '0) ? '0 : fill_wr;
    nxt_serr  = (cnt == '0) ? 1'b0 : fill_serr;
    nxt_oerr  = (cnt == '0) ? 1'b0 : fill_oerr;
    nxt_oerr  = nxt_oerr || nxt_wr[slot];
    nxt_serr  = nxt_serr || bad;
    nxt_bits[2*slot +: 2] = gray;
    nxt_wr[slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_order <= '0;
      fill_bits <= '0;
      fill_wr   <= '0;
      fill_serr <= 1'b0;
      fill_oerr <= 1'b0;
      fill_full <= 1'b0;
      out_valid <= 1'b0;
      bits_out  <= '0;
      sym_err   <= 1'b0;
      order_err <= 1'b0;
    end else begin
      if (sym_xfer) begin
        cnt       <= last ? '0 : cnt + 1'b1;
        lat_order <= order_sel;
        fill_bits <= nxt_bits;
        fill_wr   <= nxt_wr;
        fill_serr <= nxt_serr;
        fill_oerr <= nxt_oerr;
        if (last && !out_free)
          fill_full <= 1'b1;
      end
      if (sym_xfer && last && out_free) begin
        out_valid <= 1'b1;
        bits_out  <= nxt_bits;
        sym_err   <= nxt_serr;
        order_err <= nxt_oerr;
      end else if (fill_full && out_free) begin
        out_valid <= 1'b1;
        bits_out  <= fill_bits;
        sym_err   <= fill_serr;
        order_err <= fill_oerr;
        fill_full <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kbest_symbol_reorder_demap.sv
// Bench for kbest_symbol_reorder_demap: random frames against a
// frame-level reference model of the reorder and Gray demap.
module tb_kbest_symbol_reorder_demap;
  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [23:0]       colorder;
  logic              sym_valid;
  logic              sym_ready;
  logic signed [2:0] sym_in;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       bits_out;
  logic              sym_err;
  logic              order_err;

  int checks = 0;
  int errors = 0;
  int lv[4] = '{-3, -1, 1, 3};

  kbest_symbol_reorder_demap dut (
    .clk(clk), .rst(rst), .colorder(colorder),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_in(sym_in),
    .out_valid(out_valid), .out_ready(out_ready), .bits_out(bits_out),
    .sym_err(sym_err), .order_err(order_err)
  );

  always #5 clk = ~clk;

  // Reference: place each layer's Gray code at its original column
  function automatic void model(input int s[N], input logic [23:0] ord,
                                output logic [15:0] b, output logic se,
                                output logic oe);
    int hits[N];
    int g;
    int c;
    b = '0; se = 1'b0; oe = 1'b0;
    foreach (hits[i]) hits[i] = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ord[3*(N-1-k) +: 3]);
      case (s[k])
        -3: g = 0;
        -1: g = 1;
        1: g = 3;
        3: g = 2;
        default: begin g = 0; se = 1'b1; end
      endcase
      hits[c]++;
      if (hits[c] > 1) oe = 1'b1;
      b[2*c +: 2] = g[1:0];
    end
  endfunction

  function automatic logic [23:0] rand_perm();
    int p[N];
    int j;
    int t;
    logic [23:0] o;
    for (int i = 0; i < N; i++) p[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < N; i++) o[3*i +: 3] = p[i][2:0];
    return o;
  endfunction

  task automatic rand_syms(output int s[N]);
    for (int k = 0; k < N; k++) s[k] = lv[$urandom_range(3, 0)];
  endtask

  task automatic send_sym(input int s);
    int n = 0;
    sym_in = s[2:0];
    sym_valid = 1'b1;
    while (!sym_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL sym_ready_timeout waited %0d cycles, need < 50", n);
    end
    @(negedge clk);
    sym_valid = 1'b0;
  endtask

  task automatic send_frame(input int s[N], input logic [23:0] ord,
                            input bit scramble);
    colorder = ord;
    for (int k = 0; k < N; k++) begin
      send_sym(s[k]);
      if (scramble) colorder = 24'($urandom);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (sym_ready !== 1'b1) begin errors++; $display("FAIL rst_sym_ready got %b exp 1", sym_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    if (bits_out !== 16'h0) begin errors++; $display("FAIL rst_bits got %h exp 0000", bits_out); end
    if (sym_err !== 1'b0) begin errors++; $display("FAIL rst_sym_err got %b exp 0", sym_err); end
    if (order_err !== 1'b0) begin errors++; $display("FAIL rst_order_err got %b exp 0", order_err); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int s[N] = '{-3, -1, 1, 3, -3, -1, 1, 3};
    logic [23:0] ord;
    logic [15:0] eb;
    logic se, oe;
    for (int l = 0; l < N; l++) ord[3*l +: 3] = 3'(l);
    model(s, ord, eb, se, oe);
    colorder = ord;
    for (int k = 0; k < N - 1; k++) send_sym(s[k]);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL id_early_valid got %b exp 0", out_valid); end
    send_sym(s[N-1]);
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL id_valid got %b exp 1", out_valid); end
    if (bits_out !== 16'h1E1E) begin errors++; $display("FAIL id_bits got %h exp 1e1e", bits_out); end
    if (bits_out !== eb) begin errors++; $display("FAIL id_model got %h exp %h", bits_out, eb); end
    if (sym_err !== 1'b0) begin errors++; $display("FAIL id_sym_err got %b exp 0", sym_err); end
    if (order_err !== 1'b0) begin errors++; $display("FAIL id_order_err got %b exp 0", order_err); end
    consume();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL id_drop got %b exp 0", out_valid); end
    if (bits_out !== 16'h1E1E) begin errors++; $display("FAIL id_hold got %h exp 1e1e", bits_out); end
  endtask

  task automatic test_reversed();
    int s[N] = '{-3, -1, 1, 3, -3, -1, 1, 3};
    logic [23:0] ord;
    for (int l = 0; l < N; l++) ord[3*l +: 3] = 3'(N - 1 - l);
    send_frame(s, ord, 1'b1);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rev_valid got %b exp 1", out_valid); end
    if (bits_out !== 16'hB4B4) begin errors++; $display("FAIL rev_bits got %h exp b4b4", bits_out); end
    consume();
  endtask

  task automatic test_illegal();
    int s[N];
    int badv[4] = '{0, 2, -2, -4};
    logic [23:0] ord;
    logic [15:0] eb;
    logic se, oe;
    rand_syms(s);
    s[2] = badv[$urandom_range(3, 0)];
    ord = rand_perm();
    model(s, ord, eb, se, oe);
    send_frame(s, ord, 1'b0);
    checks += 3;
    if (bits_out !== eb) begin errors++; $display("FAIL ill_bits got %h exp %h", bits_out, eb); end
    if (sym_err !== 1'b1) begin errors++; $display("FAIL ill_sym_err got %b exp 1", sym_err); end
    if (order_err !== 1'b0) begin errors++; $display("FAIL ill_order_err got %b exp 0", order_err); end
    consume();
    rand_syms(s);
    ord = rand_perm();
    model(s, ord, eb, se, oe);
    send_frame(s, ord, 1'b0);
    checks += 2;
    if (bits_out !== eb) begin errors++; $display("FAIL clean_bits got %h exp %h", bits_out, eb); end
    if (sym_err !== 1'b0) begin errors++; $display("FAIL clean_sym_err got %b exp 0", sym_err); end
    consume();
  endtask

  task automatic test_duplicate();
    int s[N];
    logic [23:0] ord;
    logic [15:0] eb;
    logic se, oe;
    rand_syms(s);
    for (int l = 0; l < N; l++) ord[3*l +: 3] = (l < 2) ? 3'd0 : 3'(l);
    model(s, ord, eb, se, oe);
    send_frame(s, ord, 1'b0);
    checks += 3;
    if (order_err !== 1'b1) begin errors++; $display("FAIL dup_order_err got %b exp 1", order_err); end
    if (bits_out !== eb) begin errors++; $display("FAIL dup_bits got %h exp %h", bits_out, eb); end
    if (sym_err !== 1'b0) begin errors++; $display("FAIL dup_sym_err got %b exp 0", sym_err); end
    consume();
  endtask

  task automatic test_back_to_back();
    int s[4][N];
    logic [23:0] ord[4];
    logic [15:0] eb[4];
    logic se[4], oe[4];
    int f = 0;
    for (int i = 0; i < 4; i++) begin
      rand_syms(s[i]);
      if ($urandom_range(1, 0) == 1) s[i][$urandom_range(N-1, 0)] = 2;
      ord[i] = rand_perm();
      model(s[i], ord[i], eb[i], se[i], oe[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      if (out_valid) begin
        checks += 4;
        if (i != 8 * (f + 1)) begin errors++; $display("FAIL b2b_timing got %0d exp %0d", i, 8 * (f + 1)); end
        if (f < 4) begin
          if (bits_out !== eb[f]) begin errors++; $display("FAIL b2b_bits got %h exp %h", bits_out, eb[f]); end
          if (sym_err !== se[f]) begin errors++; $display("FAIL b2b_sym_err got %b exp %b", sym_err, se[f]); end
          if (order_err !== oe[f]) begin errors++; $display("FAIL b2b_order_err got %b exp %b", order_err, oe[f]); end
        end
        f++;
      end
      if (i < 32) begin
        checks++;
        if (sym_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", sym_ready); end
        colorder  = ord[i/8];
        sym_in    = s[i/8][i%8][2:0];
        sym_valid = 1'b1;
      end else begin
        sym_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (f != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", f); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int sa[N];
    int sb[N];
    logic [23:0] oa, ob;
    logic [15:0] ea, eb;
    logic sea, oea, seb, oeb;
    rand_syms(sa);
    sa[4] = 2;
    rand_syms(sb);
    oa = rand_perm();
    ob = rand_perm();
    ob[2:0] = ob[5:3];
    model(sa, oa, ea, sea, oea);
    model(sb, ob, eb, seb, oeb);
    out_ready = 1'b0;
    send_frame(sa, oa, 1'b0);
    colorder = ob;
    for (int k = 0; k < N; k++) begin
      send_sym(sb[k]);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
      if (bits_out !== ea) begin errors++; $display("FAIL bp_hold got %h exp %h", bits_out, ea); end
    end
    for (int i = 0; i < 4; i++) begin
      checks += 4;
      if (sym_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", sym_ready); end
      if (bits_out !== ea) begin errors++; $display("FAIL bp_stable got %h exp %h", bits_out, ea); end
      if (sym_err !== sea) begin errors++; $display("FAIL bp_sym_err got %b exp %b", sym_err, sea); end
      if (order_err !== oea) begin errors++; $display("FAIL bp_order_err got %b exp %b", order_err, oea); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (bits_out !== ea) begin errors++; $display("FAIL bp_first got %h exp %h", bits_out, ea); end
    @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b exp 1", out_valid); end
    if (bits_out !== eb) begin errors++; $display("FAIL bp_second got %h exp %h", bits_out, eb); end
    if (order_err !== oeb) begin errors++; $display("FAIL bp_second_oerr got %b exp %b", order_err, oeb); end
    if (sym_err !== seb) begin errors++; $display("FAIL bp_second_serr got %b exp %b", sym_err, seb); end
    if (sym_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b exp 1", sym_ready); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s[N];
    logic [23:0] ord;
    logic [15:0] eb;
    logic se, oe;
    rand_syms(s);
    send_frame(s, rand_perm(), 1'b0);
    rand_syms(s);
    colorder = rand_perm();
    for (int k = 0; k < 5; k++) send_sym(s[k]);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
    if (sym_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", sym_ready); end
    if (bits_out !== 16'h0) begin errors++; $display("FAIL mid_rst_bits got %h exp 0000", bits_out); end
    if (sym_err !== 1'b0 || order_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b%b exp 00", sym_err, order_err); end
    rst = 1'b0;
    rand_syms(s);
    ord = rand_perm();
    model(s, ord, eb, se, oe);
    send_frame(s, ord, 1'b0);
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid got %b exp 1", out_valid); end
    if (bits_out !== eb) begin errors++; $display("FAIL post_rst_bits got %h exp %h", bits_out, eb); end
    if (sym_err !== 1'b0 || order_err !== 1'b0) begin errors++; $display("FAIL post_rst_err got %b%b exp 00", sym_err, order_err); end
    consume();
  endtask

  initial begin
    rst = 1'b1;
    sym_valid = 1'b0;
    sym_in = '0;
    out_ready = 1'b0;
    colorder = '0;
    @(negedge clk);
    test_reset();
    test_identity();
    test_reversed();
    test_illegal();
    test_duplicate();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
